mantissa_mult_pipe: RTL and testbench

//   Pipelined, parametrised unsigned mantissa multiplier for the Posit FMAU datapath.

---
 rtl/mantissa_mult_if.sv | 28 ++
 rtl/mantissa_mult_pipe.sv | 140 ++++++++++++++
 tb/tb_mantissa_mult_pipe.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mantissa_mult_if.sv
// Valid/ready handshake bundle for the pipelined mantissa multiplier.
// The block itself uses the slave modport; the producer/consumer side uses master.
interface mantissa_mult_if #(
    parameter int W     = 28,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_prod;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_prod, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_prod, out_tag, out_err
    );
endinterface

// File: rtl/mantissa_mult_pipe.sv
// Three-stage unsigned W x W mantissa multiplier built from N x N tiles of T x T,
// with per-transaction SIMD modes (1, 2 or 4 lanes) and a tag carried alongside.
module mantissa_mult_pipe #(
    parameter int T     = 7,
    parameter int N     = 4,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mantissa_mult_if.slave   bus
);
    localparam int W   = N * T;
    localparam int PW  = 2 * W;
    localparam int PPW = 2 * T;

    typedef logic [PPW-1:0] pp_t;

    pp_t              pp_s [N*N];
    pp_t              pp_r [N*N];
    logic             v1_r;
    logic [1:0]       op1_r;
    logic [TAG_W-1:0] tag1_r;

    logic [PW-1:0]    term_s;
    logic [PW-1:0]    sum_a_s;
    logic [PW-1:0]    sum_b_s;
    logic [PW-1:0]    sum_a_r;
    logic [PW-1:0]    sum_b_r;
    logic             v2_r;
    logic [1:0]       op2_r;
    logic [TAG_W-1:0] tag2_r;

    logic             out_valid_r;
    logic [PW-1:0]    out_prod_r;
    logic [TAG_W-1:0] out_tag_r;
    logic             out_err_r;
    logic             advance_s;

    // A tile feeds the result only when its a- and b-tiles belong to the same lane.
    // Every lane product lands at bit offset (i+j)*T in all modes, so masking alone
    // keeps lanes apart and no carry can cross a lane boundary.
    function automatic logic tile_used(input logic [1:0] op, input int i, input int j);
        logic used;
        case (op)
            2'b00:   used = 1'b1;
            2'b01:   used = ((i / (N/2)) == (j / (N/2)));
            2'b10:   used = ((i / (N/4)) == (j / (N/4)));
            default: used = 1'b0;
        endcase
        return used;
    endfunction

    assign advance_s     = ~out_valid_r | bus.out_ready;
    assign bus.in_ready  = advance_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_prod  = out_prod_r;
    assign bus.out_tag   = out_tag_r;
    assign bus.out_err   = out_err_r;

    // Tile multipliers on the incoming operands.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pp_s[i*N+j] = PPW'(bus.in_a[i*T +: T]) * PPW'(bus.in_b[j*T +: T]);
            end
        end
    end

    // Stage 1: register tile products, op and tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r   <= 1'b0;
            op1_r  <= 2'b00;
            tag1_r <= '0;
            for (int k = 0; k < N*N; k++) begin
                pp_r[k] <= '0;
            end
        end else if (advance_s) begin
            v1_r   <= bus.in_valid;
            op1_r  <= bus.in_op;
            tag1_r <= bus.in_tag;
            for (int k = 0; k < N*N; k++) begin
                pp_r[k] <= pp_s[k];
            end
        end
    end

    // Column reduction into two carry-save style partial sums split by b-tile parity.
    always_comb begin
        sum_a_s = '0;
        sum_b_s = '0;
        term_s  = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (tile_used(op1_r, i, j)) begin
                    term_s = PW'(pp_r[i*N+j]) << ((i + j) * T);
                end else begin
                    term_s = '0;
                end
                if ((j % 2) == 0) begin
                    sum_a_s = sum_a_s + term_s;
                end else begin
                    sum_b_s = sum_b_s + term_s;
                end
            end
        end
    end

    // Stage 2: register the partial sums.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_r    <= 1'b0;
            op2_r   <= 2'b00;
            tag2_r  <= '0;
            sum_a_r <= '0;
            sum_b_r <= '0;
        end else if (advance_s) begin
            v2_r    <= v1_r;
            op2_r   <= op1_r;
            tag2_r  <= tag1_r;
            sum_a_r <= sum_a_s;
            sum_b_r <= sum_b_s;
        end
    end

    // Stage 3: final carry-propagate add and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_prod_r  <= '0;
            out_tag_r   <= '0;
            out_err_r   <= 1'b0;
        end else if (advance_s) begin
            out_valid_r <= v2_r;
            out_tag_r   <= tag2_r;
            out_err_r   <= (op2_r == 2'b11);
            out_prod_r  <= (op2_r == 2'b11) ? '0 : (sum_a_r + sum_b_r);
        end
    end
endmodule

// File: tb/tb_mantissa_mult_pipe.sv
// Randomized and directed bench for mantissa_mult_pipe against a lane-arithmetic
// reference model with an in-order scoreboard.
module tb_mantissa_mult_pipe;
    localparam int T     = 7;
    localparam int N     = 4;
    localparam int TAG_W = 8;
    localparam int W     = N * T;
    localparam int PW    = 2 * W;

    typedef struct {
        logic [PW-1:0]    prod;
        logic [TAG_W-1:0] tag;
        logic             err;
        int               acc;
        bit               seen;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc        = 0;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   last_stall = -1;
    int   n_acc      = 0;
    bit   acc_flag   = 1'b0;
    exp_t q[$];

    mantissa_mult_if #(.W(W), .TAG_W(TAG_W)) bus ();

    mantissa_mult_pipe #(.T(T), .N(N), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Lane products computed straight from the mode definition.
    function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] op);
        longint unsigned r, la, lb, m;
        int lanes, l;
        r = 0;
        case (op)
            2'b00:   lanes = 1;
            2'b01:   lanes = 2;
            2'b10:   lanes = 4;
            default: lanes = 0;
        endcase
        if (lanes > 0) begin
            l = W / lanes;
            m = (64'd1 << l) - 64'd1;
            for (int k = 0; k < lanes; k++) begin
                la = (64'(a) >> (k * l)) & m;
                lb = (64'(b) >> (k * l)) & m;
                r  = r | ((la * lb) << (k * 2 * l));
            end
        end
        return PW'(r);
    endfunction

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic sample();
        exp_t e;
        acc_flag = 1'b0;
        if (!rst_n) begin
            q.delete();
        end else begin
            check_val("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check_val("unexpected_out", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = q[0];
                    check_val("out_prod", 64'(bus.out_prod), 64'(e.prod));
                    check_val("out_tag", 64'(bus.out_tag), 64'(e.tag));
                    check_val("out_err", 64'(bus.out_err), 64'(e.err));
                    if (!e.seen) begin
                        if (last_stall < e.acc) check_val("latency", 64'(cyc - e.acc), 64'd3);
                        else check_val("latency_min", 64'((cyc - e.acc) >= 3), 64'd1);
                        e.seen = 1'b1;
                        q[0] = e;
                    end
                    if (bus.out_ready) void'(q.pop_front());
                end
                if (!bus.out_ready) last_stall = cyc;
            end
            if (bus.in_valid && bus.in_ready) begin
                e.prod = ref_prod(bus.in_a, bus.in_b, bus.in_op);
                e.tag  = bus.in_tag;
                e.err  = (bus.in_op == 2'b11);
                e.acc  = cyc;
                e.seen = 1'b0;
                q.push_back(e);
                acc_flag = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input logic [TAG_W-1:0] tag);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_tag   = tag;
        for (int k = 0; k < 50; k++) begin
            step();
            if (acc_flag) break;
        end
        check_val("accepted", 64'(acc_flag), 64'd1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (q.size() == 0) break;
            step();
        end
        check_val("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ones;
        ones          = '1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = 2'b00;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_out_prod", 64'(bus.out_prod), 64'd0);
        check_val("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check_val("rst_out_err", 64'(bus.out_err), 64'd0);
        rst_n = 1'b1;
        #1;
        check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Reference model against the worked examples
        check_val("ref_full", 64'(ref_prod(ones, ones, 2'b00)), 64'h00FF_FFFF_E000_0001);
        check_val("ref_two", 64'(ref_prod({14'h3FFF, 14'h3FFF}, {14'h3FFF, 14'h3FFF}, 2'b01)),
                  64'({28'hFFF8001, 28'hFFF8001}));
        check_val("ref_four", 64'(ref_prod(ones, ones, 2'b10)), 64'({4{14'h3F01}}));

        // Per-mode examples, in-order tags
        bus.out_ready = 1'b1;
        offer(ones, ones, 2'b00, 8'h01);
        offer({14'h3FFF, 14'h3FFF}, {14'h3FFF, 14'h3FFF}, 2'b01, 8'h02);
        for (int k = 0; k < 4; k++) offer(ones, ones, 2'b10, 8'(8'h11 + k));
        drain();
        idle(3);

        // Back-to-back mode changes including the reserved op
        for (int k = 0; k < 4; k++) offer(W'($urandom()), W'($urandom()), 2'(k), 8'(8'h21 + k));
        drain();
        idle(3);

        // Stall with four inputs offered
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) offer(W'($urandom()), W'($urandom()), 2'(k), 8'(8'h31 + k));
        bus.in_valid = 1'b1;
        bus.in_a     = W'($urandom());
        bus.in_b     = W'($urandom());
        bus.in_op    = 2'b11;
        bus.in_tag   = 8'h34;
        repeat (5) step();
        check_val("stall_out_valid", 64'(bus.out_valid), 64'd1);
        check_val("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check_val("stall_queue", 64'(q.size()), 64'd3);
        bus.out_ready = 1'b1;
        offer(bus.in_a, bus.in_b, bus.in_op, bus.in_tag);
        drain();
        idle(4);

        // Reset with two transactions in flight
        offer(W'($urandom()), W'($urandom()), 2'b00, 8'h41);
        offer(W'($urandom()), W'($urandom()), 2'b01, 8'h42);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        check_val("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        idle(6);

        // Random traffic with random backpressure
        for (int it = 0; it < 60000 && n_acc < 10000; it++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 8);
            bus.in_a      = ($urandom_range(0, 15) == 0) ? ones : W'($urandom());
            bus.in_b      = ($urandom_range(0, 15) == 0) ? ones : W'($urandom());
            bus.in_op     = 2'($urandom_range(0, 3));
            bus.in_tag    = TAG_W'($urandom());
            bus.out_ready = ($urandom_range(0, 9) < 8);
            step();
            if (acc_flag) n_acc++;
        end
        check_val("random_accepted", 64'(n_acc), 64'd10000);
        drain();
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
